// File: rtl/fwrisc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word-aligned memory
// requests, assembles 32-bit and compressed instructions (including ones
// split across a word boundary), and presents them to decode.
module fwrisc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          ENABLE_C     = 1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] iaddr,
   output logic        ivalid,
   input  logic        iready,
   input  logic [31:0] idata,
   output logic        fetch_valid,
   output logic [31:0] instr,
   output logic        instr_c,
   input  logic        decode_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc
);

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      FETCH_HI,
      DRAIN,
      PRESENT
   } state_t;

   state_t      state;
   logic [15:0] low_half;
   logic [31:0] drain_addr;
   logic [31:0] redir_target;
   logic [15:0] half_hi;
   logic        unused_bits;

   // Bit 0 of the redirect target is never meaningful; bit 1 only matters
   // when halfword-aligned PCs are allowed.
   assign redir_target = (ENABLE_C != 0) ? {redirect_pc[31:1], 1'b0}
                                         : {redirect_pc[31:2], 2'b00};
   assign half_hi      = idata[31:16];
   assign unused_bits  = redirect_pc[0];

   // Memory request port is a pure function of state so it stays stable
   // until the request is accepted.
   always_comb begin
      ivalid = 1'b0;
      iaddr  = 32'h0000_0000;
      case (state)
         FETCH: begin
            ivalid = 1'b1;
            iaddr  = {pc[31:2], 2'b00};
         end
         FETCH_HI: begin
            ivalid = 1'b1;
            iaddr  = {pc[31:2] + 30'd1, 2'b00};
         end
         DRAIN: begin
            ivalid = 1'b1;
            iaddr  = drain_addr;
         end
         default: begin
            ivalid = 1'b0;
            iaddr  = 32'h0000_0000;
         end
      endcase
   end

   // Fetch FSM: sequencing, instruction assembly, PC update and redirects.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         instr       <= 32'h0000_0000;
         instr_c     <= 1'b0;
         low_half    <= 16'h0000;
         drain_addr  <= 32'h0000_0000;
      end else begin
         case (state)
            BOOT: begin
               if (redirect_valid) pc <= redir_target;
               fetch_valid <= 1'b0;
               state       <= FETCH;
            end
            FETCH, FETCH_HI: begin
               if (redirect_valid) begin
                  // A request already on the bus cannot be withdrawn; if it
                  // is not yet accepted, wait it out in DRAIN.
                  pc <= redir_target;
                  if (iready) begin
                     state <= FETCH;
                  end else begin
                     drain_addr <= iaddr;
                     state      <= DRAIN;
                  end
               end else if (iready) begin
                  if (state == FETCH_HI) begin
                     instr       <= {idata[15:0], low_half};
                     instr_c     <= 1'b0;
                     fetch_valid <= 1'b1;
                     state       <= PRESENT;
                  end else if (!pc[1]) begin
                     if ((ENABLE_C != 0) && (idata[1:0] != 2'b11)) begin
                        instr   <= {16'h0000, idata[15:0]};
                        instr_c <= 1'b1;
                     end else begin
                        instr   <= idata;
                        instr_c <= 1'b0;
                     end
                     fetch_valid <= 1'b1;
                     state       <= PRESENT;
                  end else if (half_hi[1:0] != 2'b11) begin
                     instr       <= {16'h0000, half_hi};
                     instr_c     <= 1'b1;
                     fetch_valid <= 1'b1;
                     state       <= PRESENT;
                  end else begin
                     // 32-bit instruction straddles the word boundary.
                     low_half <= half_hi;
                     state    <= FETCH_HI;
                  end
               end
            end
            DRAIN: begin
               if (redirect_valid) pc <= redir_target;
               if (iready) state <= FETCH;
            end
            PRESENT: begin
               if (redirect_valid) begin
                  pc          <= redir_target;
                  fetch_valid <= 1'b0;
                  state       <= FETCH;
               end else if (decode_ready) begin
                  pc          <= pc + (instr_c ? 32'd2 : 32'd4);
                  fetch_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fwrisc_fetch_ctrl.sv
// Directed bench for fwrisc_fetch_ctrl: one instance with compressed
// support, one without, sharing the same stimulus.
module tb_fwrisc_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        iready = 1'b0;
   logic [31:0] idata = 32'h0;
   logic        decode_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   logic [31:0] iaddr_c, instr_c_w, pc_c;
   logic        ivalid_c, fv_c, ic_c;
   logic [31:0] iaddr_n, instr_n_w, pc_n;
   logic        ivalid_n, fv_n, ic_n;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   fwrisc_fetch_ctrl #(.RESET_VECTOR(32'h0), .ENABLE_C(1)) dut_c (
      .clock(clock), .reset(reset),
      .iaddr(iaddr_c), .ivalid(ivalid_c), .iready(iready), .idata(idata),
      .fetch_valid(fv_c), .instr(instr_c_w), .instr_c(ic_c),
      .decode_ready(decode_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc(pc_c)
   );

   fwrisc_fetch_ctrl #(.RESET_VECTOR(32'h0), .ENABLE_C(0)) dut_n (
      .clock(clock), .reset(reset),
      .iaddr(iaddr_n), .ivalid(ivalid_n), .iready(iready), .idata(idata),
      .fetch_valid(fv_n), .instr(instr_n_w), .instr_c(ic_n),
      .decode_ready(decode_ready), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc(pc_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      // ---- aligned 32-bit fetch after reset
      iready = 1'b1;
      idata  = 32'h00A0_0063;
      do_reset();
      check("boot_ivalid", {31'h0, ivalid_c}, 32'd0);
      check("boot_iaddr", iaddr_c, 32'h0);
      check("boot_fv", {31'h0, fv_c}, 32'd0);
      check("boot_pc", pc_c, 32'h0);
      tick();
      check("t1_ivalid", {31'h0, ivalid_c}, 32'd1);
      check("t1_iaddr", iaddr_c, 32'h0);
      tick();
      check("t1_fv", {31'h0, fv_c}, 32'd1);
      check("t1_instr", instr_c_w, 32'h00A0_0063);
      check("t1_instr_c", {31'h0, ic_c}, 32'd0);
      check("t1_present_ivalid", {31'h0, ivalid_c}, 32'd0);
      tick();
      check("t1_hold_fv", {31'h0, fv_c}, 32'd1);
      check("t1_hold_pc", pc_c, 32'h0);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t1_pc4", pc_c, 32'h4);
      check("t1_iaddr4", iaddr_c, 32'h4);
      check("t1_fv_drop", {31'h0, fv_c}, 32'd0);

      // ---- two compressed instructions in one word
      idata = 32'h4501_0001;
      do_reset();
      tick();
      tick();
      check("t2_instr0", instr_c_w, 32'h0000_0001);
      check("t2_c0", {31'h0, ic_c}, 32'd1);
      check("t2_n_c0", {31'h0, ic_n}, 32'd0);
      check("t2_n_instr0", instr_n_w, 32'h4501_0001);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t2_pc2", pc_c, 32'h2);
      check("t2_iaddr0", iaddr_c, 32'h0);
      check("t2_n_pc4", pc_n, 32'h4);
      tick();
      check("t2_instr1", instr_c_w, 32'h0000_4501);
      check("t2_c1", {31'h0, ic_c}, 32'd1);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t2_pc4", pc_c, 32'h4);

      // ---- split instruction across a word boundary
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2;
      tick();
      redirect_valid = 1'b0;
      check("t3_pc2", pc_c, 32'h2);
      check("t3_iaddr0", iaddr_c, 32'h0);
      idata = 32'h0063_1234;
      tick();
      check("t3_iaddr4", iaddr_c, 32'h4);
      check("t3_hi_ivalid", {31'h0, ivalid_c}, 32'd1);
      check("t3_hi_fv", {31'h0, fv_c}, 32'd0);
      idata = 32'h5678_00A0;
      tick();
      check("t3_instr", instr_c_w, 32'h00A0_0063);
      check("t3_instr_c", {31'h0, ic_c}, 32'd0);
      check("t3_fv", {31'h0, fv_c}, 32'd1);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t3_pc6", pc_c, 32'h6);

      // ---- redirect while a request is stalled
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8;
      iready         = 1'b0;
      tick();
      check("t4_iaddr8", iaddr_c, 32'h8);
      redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      check("t4_drain_iaddr", iaddr_c, 32'h8);
      check("t4_drain_ivalid", {31'h0, ivalid_c}, 32'd1);
      check("t4_drain_pc", pc_c, 32'h100);
      tick();
      check("t4_stall_iaddr", iaddr_c, 32'h8);
      check("t4_stall_fv", {31'h0, fv_c}, 32'd0);
      iready = 1'b1;
      idata  = 32'hDEAD_BEEF;
      tick();
      check("t4_new_iaddr", iaddr_c, 32'h100);
      check("t4_new_fv", {31'h0, fv_c}, 32'd0);
      check("t4_new_ivalid", {31'h0, ivalid_c}, 32'd1);

      // ---- redirect beats decode_ready in PRESENT
      idata = 32'h00A0_0063;
      tick();
      check("t5_fv", {31'h0, fv_c}, 32'd1);
      decode_ready   = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      decode_ready   = 1'b0;
      redirect_valid = 1'b0;
      check("t5_pc40", pc_c, 32'h40);
      check("t5_fv_drop", {31'h0, fv_c}, 32'd0);
      check("t5_iaddr40", iaddr_c, 32'h40);

      // ---- PC wrap-around
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("t7_pc_top", pc_c, 32'hFFFF_FFFC);
      tick();
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t7_pc_wrap", pc_c, 32'h0);
      check("t7_iaddr_wrap", iaddr_c, 32'h0);

      // ---- asynchronous reset while presenting
      tick();
      check("t8_pre_fv", {31'h0, fv_c}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t8_rst_fv", {31'h0, fv_c}, 32'd0);
      check("t8_rst_instr", instr_c_w, 32'h0);
      check("t8_rst_pc", pc_c, 32'h0);
      check("t8_rst_ivalid", {31'h0, ivalid_c}, 32'd0);

      // ---- 32-bit-only variant: redirect alignment and no compression
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      tick();
      redirect_valid = 1'b0;
      check("t6_n_pc", pc_n, 32'h100);
      check("t6_n_iaddr", iaddr_n, 32'h100);
      check("t6_c_pc", pc_c, 32'h102);
      idata = 32'h0000_0001;
      tick();
      check("t6_n_instr", instr_n_w, 32'h0000_0001);
      check("t6_n_instr_c", {31'h0, ic_n}, 32'd0);
      check("t6_c_instr_c", {31'h0, ic_c}, 32'd1);
      check("t6_c_instr", instr_c_w, 32'h0);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      check("t6_n_pc104", pc_n, 32'h104);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fwrisc_fetch_ctrl.md
Name: fwrisc_fetch_ctrl

Overview:
- Instruction-fetch sequencer that drives the decode stage's fetch_valid/instr/instr_c handshake.
- Owns the program counter and issues word-aligned requests on the instruction-memory valid/ready port.
- Assembles 32-bit instructions, including those split across a word boundary when compressed support is enabled.
- Applies redirects from the branch/jump path, discarding in-flight or presented instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- ENABLE_C, 1, 1 = accept 16-bit compressed instructions and halfword-aligned PCs; 0 = 32-bit only.

Ports:
- clock  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- iaddr  output  32  memory request address, always word aligned ([1:0]=0).
- ivalid  output  1  memory request valid.
- iready  input  1  memory accept; idata is valid in the same cycle.
- idata  input  32  memory read data.
- fetch_valid  output  1  instruction presented to decode.
- instr  output  32  instruction; compressed instructions are zero-extended in [15:0].
- instr_c  output  1  instr is a 16-bit compressed instruction.
- decode_ready  input  1  decode consumes the instruction.
- redirect_valid  input  1  load a new PC.
- redirect_pc  input  32  redirect target.
- pc  output  32  address of the current or pending instruction.

Behaviour:
- Reset (asynchronous): state=BOOT, pc=RESET_VECTOR, fetch_valid=0, instr=0, instr_c=0, internal low-half register=0.
- Outputs in BOOT: ivalid=0, iaddr=0.
- States and combinational outputs:
  - BOOT: ivalid=0. Goes to FETCH on the next clock.
  - FETCH: ivalid=1, iaddr={pc[31:2],2'b00}.
  - FETCH_HI: ivalid=1, iaddr={pc[31:2]+1,2'b00}.
  - DRAIN: ivalid=1, iaddr=the latched address of the abandoned request.
  - PRESENT: ivalid=0, fetch_valid=1.
- Memory rule: once ivalid=1, ivalid and iaddr stay stable until iready=1. A request is never withdrawn.
- FETCH with iready, pc[1]=0:
  - If ENABLE_C and idata[1:0]!=2'b11: instr={16'h0,idata[15:0]}, instr_c=1.
  - Otherwise instr=idata, instr_c=0.
  - Next state PRESENT.
- FETCH with iready, pc[1]=1 (only reachable when ENABLE_C=1):
  - Let h=idata[31:16].
  - If h[1:0]!=2'b11: instr={16'h0,h}, instr_c=1, next state PRESENT.
  - Otherwise latch h as the low half and go to FETCH_HI.
- FETCH_HI with iready: instr={idata[15:0],low_half}, instr_c=0, next state PRESENT.
- Fetch latency: an aligned fetch gives fetch_valid=1 in the cycle after iready. A split instruction needs two accepted requests.
- PRESENT: fetch_valid, instr and instr_c are held stable until decode_ready. On decode_ready:
  - fetch_valid drops to 0 in the next cycle.
  - pc <= pc + (instr_c ? 2 : 4), 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
  - Next state FETCH.
- Redirect, taking priority over all other events in the same cycle:
  - New pc = redirect_pc with bit 0 cleared. Bits [1:0] are also cleared when ENABLE_C=0.
  - In BOOT or PRESENT: fetch_valid=0 next cycle, next state FETCH. In PRESENT, a simultaneous decode_ready is ignored and pc is not incremented.
  - In FETCH or FETCH_HI with iready=1: idata is discarded, next state FETCH.
  - In FETCH or FETCH_HI with iready=0: latch iaddr, next state DRAIN.
  - In DRAIN: pc is updated again; the latest redirect wins.
- DRAIN with iready: data discarded, next state FETCH.
- Reset mid-operation: immediate return to reset values with no drain. The memory side tolerates a withdrawn request on reset only.
- pc output is the registered pc in every state.

Test Plan:
- Reset release, RESET_VECTOR=0, iready tied 1, idata=32'h00A00063 (beq) -> iaddr=0 in cycle 1; fetch_valid=1, instr=32'h00A00063, instr_c=0 in cycle 2; decode_ready -> pc=4, next iaddr=4.
- ENABLE_C=1, word@0=32'h4501_0001 -> first instr=32'h0000_0001, instr_c=1, pc→2; second fetch iaddr=0 gives instr=32'h0000_4501, pc→4.
- Split instruction: pc=2, word@0=32'h0063_xxxx with [17:16]=2'b11, word@4=32'hxxxx_00A0 -> two requests (iaddr 0 then 4), instr=32'h00A0_0063, instr_c=0, pc→6.
- Redirect during a stalled request: FETCH at iaddr=8 with iready=0 for 3 cycles, redirect_pc=32'h100 -> ivalid stays 1 at iaddr=8 until iready; then the data is dropped and the next request is iaddr=32'h100, with no fetch_valid in between.
- decode_ready and redirect_valid (redirect_pc=32'h40) in the same PRESENT cycle -> pc=32'h40, not pc+4; fetch_valid=0 next cycle.
- ENABLE_C=0, redirect_pc=32'h103 -> pc=32'h100, iaddr=32'h100; an idata value with [1:0]=2'b01 still gives instr_c=0.
